// File: rtl/ift_sram_pkg.sv
// -----------------------------------------------------------------------------
// ift_sram_pkg
// Shared types and helpers for the taint-tracking SRAM request adapter.
//   PKG_WIDTH     : data width the response entry type is built for
//   rsp_entry_t   : one queued response (read data, its taint, valid taint)
//   be_to_bitmask : expands a byte-enable vector to a per-bit mask
// -----------------------------------------------------------------------------
package ift_sram_pkg;

    localparam int unsigned PKG_WIDTH = 32;

    typedef struct packed {
        logic [PKG_WIDTH-1:0] rdata;
        logic [PKG_WIDTH-1:0] rdata_taint;
        logic                 vtaint;
    } rsp_entry_t;

    // Byte b of the enable vector drives bits 8b+7:8b of the mask.
    function automatic logic [PKG_WIDTH-1:0] be_to_bitmask(input logic [PKG_WIDTH/8-1:0] be);
        logic [PKG_WIDTH-1:0] mask;
        mask = '0;
        for (int b = 0; b < PKG_WIDTH / 8; b++) begin
            mask[8*b +: 8] = {8{be[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/ift_rsp_fifo.sv
// -----------------------------------------------------------------------------
// ift_rsp_fifo
// Fall-through FIFO of rsp_entry_t. When empty, a pushed entry is presented on
// the output in the same cycle; if it is also popped in that cycle it is never
// stored. Simultaneous push and pop while full is legal.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   push_i         write push_data_i this cycle
//   push_data_i    entry to enqueue
//   pop_i          consume the entry on out_data_o (only meaningful when valid)
//   out_valid_o    an entry is available (stored head or fall-through)
//   out_data_o     head entry
//   count_o        number of stored entries (excludes a fall-through entry)
// -----------------------------------------------------------------------------
module ift_rsp_fifo
    import ift_sram_pkg::*;
#(
    parameter  int unsigned Depth = 2,
    localparam int unsigned CntW  = $clog2(Depth + 1),
    localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  rsp_entry_t      push_data_i,
    input  logic            pop_i,
    output logic            out_valid_o,
    output rsp_entry_t      out_data_o,
    output logic [CntW-1:0] count_o
);

    rsp_entry_t      r_mem [Depth];
    logic [PtrW-1:0] r_rd_ptr;
    logic [PtrW-1:0] r_wr_ptr;
    logic [CntW-1:0] r_count;

    logic w_empty;
    logic w_bypass;
    logic w_store;
    logic w_take;

    // Pointers wrap at Depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_empty  = (r_count == '0);
    // Entry handed straight to the consumer without touching storage.
    assign w_bypass = w_empty & push_i & pop_i;
    assign w_store  = push_i & ~w_bypass;
    assign w_take   = pop_i & ~w_empty;

    assign out_valid_o = ~w_empty | push_i;
    assign out_data_o  = w_empty ? push_data_i : r_mem[r_rd_ptr];
    assign count_o     = r_count;

    // Storage has no reset: contents are only observable through r_count.
    always_ff @(posedge clk_i) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_take) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_store && !w_take) begin
                r_count <= r_count + 1'b1;
            end else if (!w_store && w_take) begin
                r_count <= r_count - 1'b1;
            end

            assert (r_count <= CntW'(Depth))
                else $error("ift_rsp_fifo: count exceeds depth");
            assert (!(w_store && !w_take && (r_count == CntW'(Depth))))
                else $error("ift_rsp_fifo: push into full FIFO without pop");
        end
    end

endmodule

// File: rtl/ift_sram_req_adapter.sv
// -----------------------------------------------------------------------------
// ift_sram_req_adapter
// Valid/ready front-end for the taint-tracking SRAM. Requests are forwarded to
// the SRAM port in the handshake cycle; every request produces exactly one
// in-order response, delivered through a small fall-through response FIFO.
// Taints travel conservatively alongside data.
// Ports:
//   clk_i, rst_i                        clock, synchronous active-high reset
//   req_valid_i / req_ready_o           request handshake
//   req_we_i, req_addr_i, req_wdata_i   write flag, word address, write data
//   req_be_i                            byte enables (writes only)
//   req_*_i_taint                       taints of the request fields
//   rsp_valid_o / rsp_ready_i           response handshake
//   rsp_rdata_o                         read data, zero for write acks
//   rsp_valid_o_taint, rsp_rdata_o_taint taints of the response
//   sram_req_o .. sram_wmask_o          SRAM command port
//   sram_rdata_i                        SRAM read data, one cycle after request
//   sram_*_o_taint, sram_rdata_i_taint  taints of the SRAM port
// -----------------------------------------------------------------------------
module ift_sram_req_adapter
    import ift_sram_pkg::*;
#(
    parameter int unsigned Width     = 32,
    parameter int unsigned Aw        = 15,
    parameter int unsigned NumTaints = 1,
    parameter int unsigned RspDepth  = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,

    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic                                 req_we_i,
    input  logic [Aw-1:0]                        req_addr_i,
    input  logic [Width-1:0]                     req_wdata_i,
    input  logic [Width/8-1:0]                   req_be_i,
    input  logic [NumTaints-1:0]                 req_valid_i_taint,
    input  logic [NumTaints-1:0]                 req_we_i_taint,
    input  logic [NumTaints-1:0][Aw-1:0]         req_addr_i_taint,
    input  logic [NumTaints-1:0][Width-1:0]      req_wdata_i_taint,
    input  logic [NumTaints-1:0][Width/8-1:0]    req_be_i_taint,

    output logic                                 rsp_valid_o,
    input  logic                                 rsp_ready_i,
    output logic [Width-1:0]                     rsp_rdata_o,
    output logic [NumTaints-1:0]                 rsp_valid_o_taint,
    output logic [NumTaints-1:0][Width-1:0]      rsp_rdata_o_taint,

    output logic                                 sram_req_o,
    output logic                                 sram_write_o,
    output logic [Aw-1:0]                        sram_addr_o,
    output logic [Width-1:0]                     sram_wdata_o,
    output logic [Width-1:0]                     sram_wmask_o,
    input  logic [Width-1:0]                     sram_rdata_i,
    output logic [NumTaints-1:0]                 sram_req_o_taint,
    output logic [NumTaints-1:0]                 sram_write_o_taint,
    output logic [NumTaints-1:0][Aw-1:0]         sram_addr_o_taint,
    output logic [NumTaints-1:0][Width-1:0]      sram_wdata_o_taint,
    output logic [NumTaints-1:0][Width-1:0]      sram_wmask_o_taint,
    input  logic [NumTaints-1:0][Width-1:0]      sram_rdata_i_taint
);

    localparam int unsigned CntW = $clog2(RspDepth + 1);

    // Unsupported configurations stop elaboration.
    if (NumTaints != 1) begin : g_bad_num_taints
        $error("ift_sram_req_adapter: only NumTaints == 1 is supported");
    end
    if (Width != PKG_WIDTH) begin : g_bad_width
        $error("ift_sram_req_adapter: Width must match ift_sram_pkg::PKG_WIDTH");
    end
    if (RspDepth < 2) begin : g_bad_depth
        $error("ift_sram_req_adapter: RspDepth must be at least 2");
    end

    // The request accepted last cycle: its response is produced this cycle.
    logic r_inflight;
    logic r_infl_we;
    logic r_infl_we_taint;
    logic r_infl_vtaint;

    logic            w_handshake;
    logic            w_credit_ok;
    logic            w_push;
    logic            w_pop;
    logic            w_fifo_valid;
    rsp_entry_t      w_push_entry;
    rsp_entry_t      w_head;
    logic [CntW-1:0] w_fifo_count;

    // Credits are counted from registered state only (stored entries plus the
    // one response being produced), so rsp_ready_i never reaches req_ready_o.
    assign w_credit_ok = (32'(w_fifo_count) + 32'(r_inflight)) < RspDepth;
    assign req_ready_o = ~rst_i & w_credit_ok;
    assign w_handshake = req_valid_i & req_ready_o;

    assign sram_req_o   = w_handshake;
    assign sram_write_o = req_we_i;
    assign sram_addr_o  = req_addr_i;
    assign sram_wdata_o = req_wdata_i;
    assign sram_wmask_o = req_we_i ? be_to_bitmask(req_be_i) : '0;

    // Request-path taints are forced low while in reset.
    genvar gi;
    for (gi = 0; gi < NumTaints; gi++) begin : g_req_taint
        assign sram_req_o_taint[gi]   = req_valid_i_taint[gi] & req_ready_o;
        assign sram_write_o_taint[gi] = req_we_i_taint[gi] & ~rst_i;
        assign sram_addr_o_taint[gi]  = rst_i ? '0 : req_addr_i_taint[gi];
        assign sram_wdata_o_taint[gi] = rst_i ? '0 : req_wdata_i_taint[gi];
        // A tainted write flag may or may not have written anything: taint the
        // whole mask.
        assign sram_wmask_o_taint[gi] = rst_i ? '0 :
            (be_to_bitmask(req_be_i_taint[gi]) | {Width{req_we_i_taint[gi]}});
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_inflight      <= 1'b0;
            r_infl_we       <= 1'b0;
            r_infl_we_taint <= 1'b0;
            r_infl_vtaint   <= 1'b0;
        end else begin
            r_inflight <= w_handshake;
            if (w_handshake) begin
                r_infl_we       <= req_we_i;
                r_infl_we_taint <= req_we_i_taint[0];
                r_infl_vtaint   <= req_valid_i_taint[0] | req_we_i_taint[0];
            end
        end
    end

    // Reads and writes both enter the FIFO one cycle after acceptance, so there
    // is at most one push per cycle and responses stay in request order. Write
    // acks therefore appear at T+1 just like read data.
    always_comb begin
        w_push_entry             = '0;
        w_push_entry.vtaint      = r_infl_vtaint;
        w_push_entry.rdata       = r_infl_we ? '0 : sram_rdata_i;
        w_push_entry.rdata_taint = (r_infl_we ? '0 : sram_rdata_i_taint[0])
                                 | {PKG_WIDTH{r_infl_we_taint}};
    end

    assign w_push = r_inflight & ~rst_i;
    assign w_pop  = rsp_valid_o & rsp_ready_i;

    ift_rsp_fifo #(
        .Depth (RspDepth)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .out_valid_o (w_fifo_valid),
        .out_data_o  (w_head),
        .count_o     (w_fifo_count)
    );

    // Outputs read zero whenever no response is offered.
    assign rsp_valid_o          = ~rst_i & w_fifo_valid;
    assign rsp_rdata_o          = rsp_valid_o ? w_head.rdata : '0;
    assign rsp_valid_o_taint[0] = rsp_valid_o & w_head.vtaint;
    assign rsp_rdata_o_taint[0] = rsp_valid_o ? w_head.rdata_taint : '0;

endmodule

// File: tb/tb_ift_sram_req_adapter.sv
module tb_ift_sram_req_adapter;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                     rst_i;
    logic                     req_valid_i;
    logic                     req_ready_o;
    logic                     req_we_i;
    logic [14:0]              req_addr_i;
    logic [31:0]              req_wdata_i;
    logic [3:0]               req_be_i;
    logic [0:0]               req_valid_i_taint;
    logic [0:0]               req_we_i_taint;
    logic [0:0][14:0]         req_addr_i_taint;
    logic [0:0][31:0]         req_wdata_i_taint;
    logic [0:0][3:0]          req_be_i_taint;
    logic                     rsp_valid_o;
    logic                     rsp_ready_i;
    logic [31:0]              rsp_rdata_o;
    logic [0:0]               rsp_valid_o_taint;
    logic [0:0][31:0]         rsp_rdata_o_taint;
    logic                     sram_req_o;
    logic                     sram_write_o;
    logic [14:0]              sram_addr_o;
    logic [31:0]              sram_wdata_o;
    logic [31:0]              sram_wmask_o;
    logic [31:0]              sram_rdata_i;
    logic [0:0]               sram_req_o_taint;
    logic [0:0]               sram_write_o_taint;
    logic [0:0][14:0]         sram_addr_o_taint;
    logic [0:0][31:0]         sram_wdata_o_taint;
    logic [0:0][31:0]         sram_wmask_o_taint;
    logic [0:0][31:0]         sram_rdata_i_taint;

    ift_sram_req_adapter #(
        .Width(32), .Aw(15), .NumTaints(1), .RspDepth(2)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .req_valid_i_taint(req_valid_i_taint), .req_we_i_taint(req_we_i_taint),
        .req_addr_i_taint(req_addr_i_taint), .req_wdata_i_taint(req_wdata_i_taint),
        .req_be_i_taint(req_be_i_taint),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_valid_o_taint(rsp_valid_o_taint), .rsp_rdata_o_taint(rsp_rdata_o_taint),
        .sram_req_o(sram_req_o), .sram_write_o(sram_write_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_wmask_o(sram_wmask_o), .sram_rdata_i(sram_rdata_i),
        .sram_req_o_taint(sram_req_o_taint), .sram_write_o_taint(sram_write_o_taint),
        .sram_addr_o_taint(sram_addr_o_taint), .sram_wdata_o_taint(sram_wdata_o_taint),
        .sram_wmask_o_taint(sram_wmask_o_taint), .sram_rdata_i_taint(sram_rdata_i_taint)
    );

    // Behavioural SRAM: masked writes, 1-cycle read latency.
    logic [31:0] mem [0:255];
    logic [31:0] rtaint_drive;
    assign sram_rdata_i_taint[0] = rtaint_drive;

    always @(posedge clk_i) begin
        if (sram_req_o) begin
            if (sram_write_o)
                mem[sram_addr_o[7:0]] <= (mem[sram_addr_o[7:0]] & ~sram_wmask_o)
                                       | (sram_wdata_o & sram_wmask_o);
            else
                sram_rdata_i <= mem[sram_addr_o[7:0]];
        end
    end

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] rtaint;
        logic        vt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Values seen on the SRAM port in the most recent handshake cycle.
    logic        cap_req, cap_write, cap_req_t, cap_write_t;
    logic [14:0] cap_addr, cap_addr_t;
    logic [31:0] cap_wdata, cap_mask, cap_mask_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted response is compared with the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i && rsp_valid_o && rsp_ready_i) begin
                $display("rsp rdata=0x%08h rtaint=0x%08h vtaint=%0d", rsp_rdata_o,
                         rsp_rdata_o_taint[0], rsp_valid_o_taint[0]);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got rdata 0x%0h, expected no response", rsp_rdata_o);
                end else begin
                    e = sb.pop_front();
                    check("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
                    check("rsp_rdata_taint", 64'(rsp_rdata_o_taint[0]), 64'(e.rtaint));
                    check("rsp_valid_taint", 64'(rsp_valid_o_taint[0]), 64'(e.vt));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_req();
        req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0; req_be_i = '0;
        req_valid_i_taint = '0; req_we_i_taint = '0; req_addr_i_taint = '0;
        req_wdata_i_taint = '0; req_be_i_taint = '0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Waits (bounded) for the handshake of the currently driven request.
    task automatic wait_accept(output int waited);
        logic acc;
        acc = 1'b0;
        waited = 0;
        while (!acc && waited < 20) begin
            @(negedge clk_i);
            if (req_ready_o) begin
                acc = 1'b1;
                cap_req = sram_req_o;     cap_write = sram_write_o;
                cap_addr = sram_addr_o;   cap_wdata = sram_wdata_o;
                cap_mask = sram_wmask_o;  cap_mask_t = sram_wmask_o_taint[0];
                cap_req_t = sram_req_o_taint[0]; cap_write_t = sram_write_o_taint[0];
                cap_addr_t = sram_addr_o_taint[0];
                $display("req we=%0d addr=0x%0h wdata=0x%08h be=0x%0h wmask=0x%08h",
                         req_we_i, req_addr_i, req_wdata_i, req_be_i, sram_wmask_o);
            end else begin
                waited++;
            end
            step();
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no handshake in 20 cycles, expected one");
        end
    endtask

    task automatic send(input logic we, input logic [14:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] e_mask,
                        input logic [31:0] e_rdata, input logic [31:0] e_rtaint,
                        input logic e_vt, output int waited);
        exp_t e;
        req_we_i = we; req_addr_i = addr; req_wdata_i = wdata; req_be_i = be;
        req_valid_i = 1'b1;
        e.rdata = e_rdata; e.rtaint = e_rtaint; e.vt = e_vt;
        sb.push_back(e);
        wait_accept(waited);
        req_valid_i = 1'b0;
        check("sram_req", 64'(cap_req), 64'h1);
        check("sram_write", 64'(cap_write), 64'(we));
        check("sram_addr", 64'(cap_addr), 64'(addr));
        check("sram_wmask", 64'(cap_mask), 64'(e_mask));
        if (we) check("sram_wdata", 64'(cap_wdata), 64'(wdata));
    endtask

    initial begin
        int w;
        exp_t e3;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h20] = 32'h11111111;
        mem[8'h21] = 32'h22222222;
        mem[8'h22] = 32'h33333333;
        mem[8'h30] = 32'h12345678;
        rtaint_drive = '0;
        clear_req();
        rsp_ready_i = 1'b1;
        rst_i = 1'b1;

        // Reset: requests and taints driven, everything must stay quiet.
        req_valid_i = 1'b1; req_valid_i_taint = 1'b1; req_we_i_taint = 1'b1;
        repeat (2) step();
        @(negedge clk_i);
        check("rst_req_ready", 64'(req_ready_o), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
        check("rst_sram_req", 64'(sram_req_o), 64'h0);
        check("rst_sram_req_taint", 64'(sram_req_o_taint[0]), 64'h0);
        check("rst_sram_write_taint", 64'(sram_write_o_taint[0]), 64'h0);
        check("rst_rsp_valid_taint", 64'(rsp_valid_o_taint[0]), 64'h0);
        check("rst_rsp_rdata_taint", 64'(rsp_rdata_o_taint[0]), 64'h0);
        clear_req();
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_req_ready", 64'(req_ready_o), 64'h1);
        step();

        // 1. Plain read, response at T+1.
        send(1'b0, 15'h10, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, w);
        @(negedge clk_i);
        check("t1_rsp_latency", 64'(rsp_valid_o), 64'h1);
        check("t1_rsp_data", 64'(rsp_rdata_o), 64'hDEADBEEF);
        step();

        // 2. Byte-strobed write, ack at T+1, then read back.
        send(1'b1, 15'h3, 32'hA5A5A5A5, 4'b0101, 32'h00FF00FF, 32'h0, 32'h0, 1'b0, w);
        @(negedge clk_i);
        check("t2_ack_latency", 64'(rsp_valid_o), 64'h1);
        step();
        send(1'b0, 15'h3, 32'h0, 4'h0, 32'h0, 32'h00A500A5, 32'h0, 1'b0, w);
        step();

        // Back-to-back reads with rsp_ready_i=1 are accepted every cycle.
        send(1'b0, 15'h20, 32'h0, 4'h0, 32'h0, 32'h11111111, 32'h0, 1'b0, w);
        send(1'b0, 15'h21, 32'h0, 4'h0, 32'h0, 32'h22222222, 32'h0, 1'b0, w);
        check("b2b_wait_2nd", 64'(w), 64'h0);
        send(1'b0, 15'h22, 32'h0, 4'h0, 32'h0, 32'h33333333, 32'h0, 1'b0, w);
        check("b2b_wait_3rd", 64'(w), 64'h0);
        repeat (2) step();

        // 3. Back-pressure: two accepted, third waits for the first pop.
        rsp_ready_i = 1'b0;
        send(1'b0, 15'h20, 32'h0, 4'h0, 32'h0, 32'h11111111, 32'h0, 1'b0, w);
        send(1'b0, 15'h21, 32'h0, 4'h0, 32'h0, 32'h22222222, 32'h0, 1'b0, w);
        check("t3_second_no_wait", 64'(w), 64'h0);
        req_we_i = 1'b0; req_addr_i = 15'h22; req_valid_i = 1'b1;
        e3.rdata = 32'h33333333; e3.rtaint = '0; e3.vt = 1'b0;
        sb.push_back(e3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("t3_ready_low_full", 64'(req_ready_o), 64'h0);
            step();
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        check("t3_ready_low_at_pop", 64'(req_ready_o), 64'h0);
        step();
        wait_accept(w);
        req_valid_i = 1'b0;
        check("t3_accept_after_pop", 64'(w), 64'h0);
        check("t3_sram_addr", 64'(cap_addr), 64'h22);
        repeat (3) step();

        // 4. Read with address taint and tainted SRAM data.
        rtaint_drive = 32'hFFFFFFFF;
        req_addr_i_taint[0] = 15'h1;
        send(1'b0, 15'h30, 32'h0, 4'h0, 32'h0, 32'h12345678, 32'hFFFFFFFF, 1'b0, w);
        check("t4_addr_taint", 64'(cap_addr_t), 64'h1);
        req_addr_i_taint[0] = '0;
        @(negedge clk_i);
        step();
        rtaint_drive = '0;

        // 5. Write with tainted write flag.
        req_we_i_taint = 1'b1;
        send(1'b1, 15'h40, 32'h0, 4'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b1, w);
        check("t5_wmask_taint", 64'(cap_mask_t), 64'hFFFFFFFF);
        check("t5_write_taint", 64'(cap_write_t), 64'h1);
        req_we_i_taint = 1'b0;
        step();

        // Read with tainted valid: valid taint reaches SRAM req and response.
        req_valid_i_taint = 1'b1;
        send(1'b0, 15'h10, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b1, w);
        check("tv_req_taint", 64'(cap_req_t), 64'h1);
        req_valid_i_taint = 1'b0;
        repeat (2) step();

        // 6. Reset while a read is in flight and one entry is queued.
        rsp_ready_i = 1'b0;
        send(1'b0, 15'h20, 32'h0, 4'h0, 32'h0, 32'h11111111, 32'h0, 1'b0, w);
        send(1'b0, 15'h21, 32'h0, 4'h0, 32'h0, 32'h22222222, 32'h0, 1'b0, w);
        rst_i = 1'b1;
        sb.delete();
        @(negedge clk_i);
        check("t6_rsp_valid_in_rst", 64'(rsp_valid_o), 64'h0);
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("t6_rsp_valid_after", 64'(rsp_valid_o), 64'h0);
        check("t6_ready_after", 64'(req_ready_o), 64'h1);
        step();
        @(negedge clk_i);
        check("t6_fifo_empty", 64'(rsp_valid_o), 64'h0);
        step();
        rsp_ready_i = 1'b1;
        send(1'b0, 15'h10, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, w);
        repeat (3) step();

        check("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
